// File: rtl/uart_cmd_regs_pkg.sv
// Shared constants, state encoding and checksum helper for the UART command-frame parser.
package uart_cmd_regs_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] NAK_BYTE  = 8'hEE;
  localparam logic [7:0] ACK_FLAG  = 8'h80;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CSUM = 2'd3
  } state_t;

  function automatic logic [7:0] frame_csum(input logic [7:0] addr, input logic [7:0] data);
    return SYNC_BYTE ^ addr ^ data;
  endfunction

endpackage

// File: rtl/cmd_timer.sv
// Loadable down-counter guarding the gap between bytes of one frame.
// Load has priority over counting; the count parks at zero.
module cmd_timer #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/uart_cmd_regs.sv
// Parses SYNC/ADDR/DATA/CSUM UART frames into an 8-bit register bank with timeout and error count.
// Optional ack/nak echo towards acia_tx is built only when CMD_ECHO_EN is defined.
module uart_cmd_regs
  import uart_cmd_regs_pkg::*;
#(
  parameter int         NREGS       = 4,
  parameter int         TIMEOUT_CYC = 1760000,
  parameter logic [7:0] RST_VAL     = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_dat,
  input  logic               rx_stb,
  input  logic               rx_err,
  output logic [NREGS*8-1:0] regs_flat,
  output logic               wr_stb,
  output logic [7:0]         wr_addr,
  output logic [7:0]         err_cnt,
  output logic               busy,
  output logic [7:0]         tx_dat,
  output logic               tx_start,
  input  logic               tx_busy
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t     state, state_nx;
  logic [7:0] addr_q, data_q;
  logic       latch_addr, latch_data, commit, reject;
  logic       tmr_zero, timeout, addr_ok;

  cmd_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (rx_stb),
    .en       (state != S_IDLE),
    .load_val (TW'(TIMEOUT_CYC - 1)),
    .zero     (tmr_zero)
  );

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = (state != S_IDLE) && tmr_zero && !rx_stb;
  assign addr_ok = 32'(addr_q) < NREGS;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nx   = state;
    latch_addr = 1'b0;
    latch_data = 1'b0;
    commit     = 1'b0;
    reject     = 1'b0;
    if (rx_stb && rx_err) begin
      reject   = 1'b1;
      state_nx = S_IDLE;
    end else if (rx_stb) begin
      case (state)
        S_IDLE: if (rx_dat == SYNC_BYTE) state_nx = S_ADDR;
        S_ADDR: begin latch_addr = 1'b1; state_nx = S_DATA; end
        S_DATA: begin latch_data = 1'b1; state_nx = S_CSUM; end
        S_CSUM: begin
          state_nx = S_IDLE;
          if (rx_dat == frame_csum(addr_q, data_q) && addr_ok) commit = 1'b1;
          else                                                 reject = 1'b1;
        end
        default: state_nx = S_IDLE;
      endcase
    end else if (timeout) begin
      reject   = 1'b1;
      state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      wr_stb  <= 1'b0;
      wr_addr <= 8'h00;
      err_cnt <= 8'h00;
    end else begin
      if (latch_addr) addr_q <= rx_dat;
      if (latch_data) data_q <= rx_dat;
      wr_stb <= commit;
      if (commit) wr_addr <= addr_q;
      if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // NOTE: the bank is plain flops rather than a RAM, so it can take the async reset value.
  for (genvar i = 0; i < NREGS; i++) begin : g_bank
    logic [7:0] r;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                          r <= RST_VAL;
      else if (commit && addr_q == 8'(i)) r <= data_q;
    end
    assign regs_flat[8*i +: 8] = r;
  end

`ifdef CMD_ECHO_EN
  logic       ack_pend;
  logic [7:0] ack_dat;

  // A fresh ack replaces any still-pending one; launch waits for acia_tx to go idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_pend <= 1'b0;
      ack_dat  <= 8'h00;
      tx_start <= 1'b0;
      tx_dat   <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      if (commit || reject) begin
        ack_pend <= 1'b1;
        ack_dat  <= commit ? (ACK_FLAG | {1'b0, addr_q[6:0]}) : NAK_BYTE;
      end else if (ack_pend && !tx_busy) begin
        ack_pend <= 1'b0;
        tx_start <= 1'b1;
        tx_dat   <= ack_dat;
      end
    end
  end
`else
  logic unused_tx_busy;
  assign unused_tx_busy = tx_busy;
  assign tx_dat         = 8'h00;
  assign tx_start       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_regs.sv
// Scoreboard bench for uart_cmd_regs: expected writes queued at stimulus, popped on wr_stb.
module tb_uart_cmd_regs;

  localparam int NREGS = 4;
  localparam int TCYC  = 40;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         rx_dat;
  logic               rx_stb, rx_err, tx_busy;
  logic [NREGS*8-1:0] regs_flat;
  logic               wr_stb, busy, tx_start;
  logic [7:0]         wr_addr, err_cnt, tx_dat;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        sb_q[$];
  logic [7:0] exp_regs[NREGS];
  int         exp_err;
  int         checks   = 0;
  int         failures = 0;
  int         tx_cnt   = 0;
  logic [7:0] tx_last  = 8'h00;

  uart_cmd_regs #(.NREGS(NREGS), .TIMEOUT_CYC(TCYC), .RST_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_dat    (rx_dat),
    .rx_stb    (rx_stb),
    .rx_err    (rx_err),
    .regs_flat (regs_flat),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .err_cnt   (err_cnt),
    .busy      (busy),
    .tx_dat    (tx_dat),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREGS*8-1:0] exp_flat();
    logic [NREGS*8-1:0] f;
    for (int i = 0; i < NREGS; i++) f[8*i +: 8] = exp_regs[i];
    return f;
  endfunction

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called one time unit after a rising edge; the strobe lands gap cycles later.
  task automatic send_byte(input logic [7:0] b, input logic e, input int gap);
    tick(gap);
    rx_dat = b;
    rx_err = e;
    rx_stb = 1'b1;
    tick(1);
    rx_stb = 1'b0;
    rx_err = 1'b0;
    rx_dat = 8'h00;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_regs"}, 32'(regs_flat), 32'(exp_flat()));
    check({tag, "_err"},  32'(err_cnt),   32'(exp_err));
    check({tag, "_busy"}, 32'(busy),      32'd0);
  endtask

  task automatic send_frame(input string tag, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] c, input int gap);
    if (c == (8'hA5 ^ a ^ d) && a < NREGS) begin
      sb_q.push_back('{addr: a, data: d});
      exp_regs[a] = d;
    end else begin
      bump_err();
    end
    send_byte(8'hA5, 1'b0, gap);
    send_byte(a, 1'b0, gap);
    send_byte(d, 1'b0, gap);
    send_byte(c, 1'b0, gap);
    tick(2);
    check_state(tag);
  endtask

  always @(negedge clk) begin
    if (!rst && wr_stb) begin
      if (sb_q.size() == 0) begin
        check("wr_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(regs_flat[8*e.addr[1:0] +: 8]), 32'(e.data));
      end
    end
    if (!rst && tx_start) begin
      tx_cnt++;
      tx_last = tx_dat;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_dat = 8'h00; rx_stb = 1'b0; rx_err = 1'b0; tx_busy = 1'b0;
    for (int i = 0; i < NREGS; i++) exp_regs[i] = 8'h00;
    exp_err = 0;
    tick(3);
    rst = 1'b0;
    tick(1);

    check_state("reset");
    check("reset_wr_stb",   32'(wr_stb),   32'd0);
    check("reset_wr_addr",  32'(wr_addr),  32'd0);
    check("reset_tx_start", 32'(tx_start), 32'd0);
    check("reset_tx_dat",   32'(tx_dat),   32'd0);

    send_frame("t1_commit", 8'h02, 8'h3C, 8'h9B, 0);
    check("t1_wr_addr", 32'(wr_addr), 32'd2);
    send_frame("t2_badcsum", 8'h01, 8'h10, 8'h00, 0);
    send_frame("t3_badaddr", 8'h07, 8'h55, 8'hF7, 0);

    send_byte(8'h33, 1'b0, 0);
    tick(1);
    check_state("idle_ignore");

    send_byte(8'hA5, 1'b1, 0);
    bump_err();
    tick(1);
    check_state("idle_rxerr");

    send_byte(8'hA5, 1'b0, 0);
    check("mid_busy", 32'(busy), 32'd1);
    send_byte(8'h01, 1'b1, 0);
    bump_err();
    tick(1);
    check_state("mid_rxerr");

    send_frame("sync_payload", 8'h01, 8'hA5, 8'h01, 0);

    send_byte(8'hA5, 1'b0, 0);
    send_byte(8'h01, 1'b0, 0);
    tick(TCYC - 1);
    check("to_busy_hold", 32'(busy), 32'd1);
    tick(1);
    bump_err();
    check_state("t4_timeout");
    send_frame("t4_after", 8'h03, 8'hFF, 8'h59, 0);

    send_frame("t5_edge_gap", 8'h00, 8'h77, 8'hD2, TCYC - 1);

    send_byte(8'hA5, 1'b0, 0);
    send_byte(8'h01, 1'b0, TCYC);
    bump_err();
    tick(1);
    check_state("late_byte");

    for (int n = 0; n < 300; n++) send_frame("t5_flood", 8'h01, 8'h10, 8'h00, 0);
    check("t5_err_sat", 32'(err_cnt), 32'd255);

`ifdef CMD_ECHO_EN
    tx_busy = 1'b1;
    tick(3);
    tx_cnt = 0;
    send_frame("t6_commit", 8'h02, 8'h3C, 8'h9B, 0);
    tick(8);
    check("t6_held", 32'(tx_cnt), 32'd0);
    tx_busy = 1'b0;
    tick(10);
    check("t6_one_start", 32'(tx_cnt), 32'd1);
    check("t6_ack", 32'(tx_last), 32'h82);

    tx_busy = 1'b1;
    tick(1);
    tx_cnt = 0;
    send_frame("t6_nak", 8'h01, 8'h10, 8'h00, 0);
    send_frame("t6_ack2", 8'h01, 8'h10, 8'hB4, 0);
    tx_busy = 1'b0;
    tick(10);
    check("t6_latest_cnt", 32'(tx_cnt), 32'd1);
    check("t6_latest_dat", 32'(tx_last), 32'h81);
`else
    check("no_echo_starts", 32'(tx_cnt), 32'd0);
`endif

    send_byte(8'hA5, 1'b0, 0);
    send_byte(8'h01, 1'b0, 0);
    rst = 1'b1;
    #2;
    for (int i = 0; i < NREGS; i++) exp_regs[i] = 8'h00;
    exp_err = 0;
    check_state("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    send_frame("post_rst", 8'h02, 8'h3C, 8'h9B, 0);

    tick(3);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
